// File: rtl/or_arbiter.sv
// Round-robin arbiter sharing one bitwise-OR datapath among four requesters,
// with a single-entry valid/ready output register tagged by requester index.
module or_arbiter #(
  parameter int WIDTH = 5,
  parameter int NREQ  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] a_in,
  input  logic [NREQ*WIDTH-1:0] b_in,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      z,
  output logic [1:0]            z_id,
  output logic                  z_valid,
  input  logic                  z_ready
);

  logic [1:0]       ptr;
  logic [1:0]       win_idx;
  logic             win_valid;
  logic             can_accept;
  logic [1:0]       idx;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;

  assign can_accept = !z_valid || z_ready;

  // Search starts at ptr and wraps; the first pending requester wins.
  always_comb begin
    win_idx   = 2'd0;
    win_valid = 1'b0;
    idx       = 2'd0;
    for (int k = 0; k < NREQ; k++) begin
      idx = ptr + 2'(k);
      if (!win_valid && req[idx]) begin
        win_valid = 1'b1;
        win_idx   = idx;
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (!rst && can_accept && win_valid) begin
      gnt[win_idx] = 1'b1;
    end
  end

  assign a_sel = a_in[win_idx*WIDTH +: WIDTH];
  assign b_sel = b_in[win_idx*WIDTH +: WIDTH];

  // A grant may load over a result being consumed on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      z       <= '0;
      z_id    <= 2'd0;
      z_valid <= 1'b0;
      ptr     <= 2'd0;
    end else if (|gnt) begin
      z       <= a_sel | b_sel;
      z_id    <= win_idx;
      z_valid <= 1'b1;
      ptr     <= win_idx + 2'd1;
    end else if (z_ready) begin
      z_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_or_arbiter.sv
// Self-checking bench for or_arbiter: directed vector table followed by a
// randomized phase checked against a round-robin model and result scoreboard.
module tb_or_arbiter;

  localparam int W = 5;
  localparam int N = 4;

  localparam logic [19:0] RR_A   = {5'b01000, 5'b00100, 5'b00010, 5'b00001};
  localparam logic [19:0] SGL_A  = {15'd0, 5'b10100};
  localparam logic [19:0] SGL_B  = {15'd0, 5'b00011};
  localparam logic [19:0] BP_A   = {10'd0, 5'b11000, 5'd0};
  localparam logic [19:0] BP_B   = {10'd0, 5'b00001, 5'd0};
  localparam logic [19:0] SK_A   = {5'b00100, 10'd0, 5'b10000};
  localparam logic [19:0] SK_B   = {5'b00010, 10'd0, 5'b00001};

  logic          clk;
  logic          rst;
  logic [N-1:0]  req;
  logic [N*W-1:0] a_in;
  logic [N*W-1:0] b_in;
  logic [N-1:0]  gnt;
  logic [W-1:0]  z;
  logic [1:0]    z_id;
  logic          z_valid;
  logic          z_ready;

  or_arbiter #(.WIDTH(W), .NREQ(N)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .z(z), .z_id(z_id), .z_valid(z_valid), .z_ready(z_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [19:0] a;
    logic [19:0] b;
    logic        rdy;
    logic [3:0]  exp_gnt;
    logic        exp_zv;
  } vec_t;

  vec_t         vecs[$];
  logic [6:0]   sb[$];
  int           checks = 0;
  int           failures = 0;
  int           step = 0;
  logic         pushed = 1'b0;
  logic         mon_en = 1'b0;
  logic [3:0]   last_gnt = 4'd0;
  logic [W-1:0] exp_z = '0;
  logic [1:0]   exp_id = 2'd0;

  function automatic logic [3:0] rr_pick(input logic [3:0] rq, input logic [1:0] p);
    logic [3:0] g;
    logic [1:0] j;
    g = 4'd0;
    for (int k = 0; k < 4; k++) begin
      j = p + 2'(k);
      if (g == 4'd0 && rq[j]) g[j] = 1'b1;
    end
    return g;
  endfunction

  // Drive one cycle of inputs, check the combinational grant, queue the expected result.
  task automatic applyStimulus(input logic r, input logic [3:0] rq, input logic [19:0] av,
                               input logic [19:0] bv, input logic rd, input logic [3:0] eg);
    @(negedge clk);
    if (mon_en && !r) begin
      checks++;
      if ((req & ~rq & ~last_gnt) != 4'd0) begin
        failures++;
        $display("[TB] FAIL req_withdrawn step=%0d actual=%b required_kept=%b", step, rq, req & ~last_gnt);
      end
    end
    rst = r; req = rq; a_in = av; b_in = bv; z_ready = rd;
    #2;
    checks++;
    if (gnt !== eg) begin
      failures++;
      $display("[TB] FAIL gnt step=%0d actual=%b required=%b", step, gnt, eg);
    end
    last_gnt = eg;
    pushed = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (eg[i]) begin
        sb.push_back({av[i*W +: W] | bv[i*W +: W], 2'(i)});
        pushed = 1'b1;
      end
    end
  endtask

  // After the edge, compare the registered outputs with the scoreboard.
  task automatic checkOutput(input logic r, input logic ezv);
    logic [6:0] e;
    @(posedge clk);
    #1;
    if (r) begin
      exp_z = '0; exp_id = 2'd0;
    end else if (pushed) begin
      e = sb.pop_front();
      exp_z = e[6:2]; exp_id = e[1:0];
    end
    checks++;
    if (z_valid !== ezv) begin
      failures++;
      $display("[TB] FAIL z_valid step=%0d actual=%b required=%b", step, z_valid, ezv);
    end
    checks++;
    if (z !== exp_z) begin
      failures++;
      $display("[TB] FAIL z step=%0d actual=%b required=%b", step, z, exp_z);
    end
    checks++;
    if (z_id !== exp_id) begin
      failures++;
      $display("[TB] FAIL z_id step=%0d actual=%0d required=%0d", step, z_id, exp_id);
    end
    step++;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0]  pend;
    logic [19:0] ra, rb;
    logic        rd;
    logic [3:0]  eg;
    logic [1:0]  m_ptr;
    logic        m_zv;

    rst = 1'b1; req = '0; a_in = '0; b_in = '0; z_ready = 1'b0;

    // reset with all requesting, then round robin 0,1,2,3,0
    vecs.push_back('{1'b1, 4'b1111, RR_A, 20'd0, 1'b1, 4'b0000, 1'b0});
    vecs.push_back('{1'b1, 4'b1111, RR_A, 20'd0, 1'b1, 4'b0000, 1'b0});
    vecs.push_back('{1'b0, 4'b1111, RR_A, 20'd0, 1'b1, 4'b0001, 1'b1});
    vecs.push_back('{1'b0, 4'b1111, RR_A, 20'd0, 1'b1, 4'b0010, 1'b1});
    vecs.push_back('{1'b0, 4'b1111, RR_A, 20'd0, 1'b1, 4'b0100, 1'b1});
    vecs.push_back('{1'b0, 4'b1111, RR_A, 20'd0, 1'b1, 4'b1000, 1'b1});
    vecs.push_back('{1'b0, 4'b1111, RR_A, 20'd0, 1'b1, 4'b0001, 1'b1});
    // single request, then backpressure stall and release
    vecs.push_back('{1'b0, 4'b0001, SGL_A, SGL_B, 1'b1, 4'b0001, 1'b1});
    vecs.push_back('{1'b0, 4'b0010, BP_A, BP_B, 1'b0, 4'b0000, 1'b1});
    vecs.push_back('{1'b0, 4'b0010, BP_A, BP_B, 1'b0, 4'b0000, 1'b1});
    vecs.push_back('{1'b0, 4'b0010, BP_A, BP_B, 1'b0, 4'b0000, 1'b1});
    vecs.push_back('{1'b0, 4'b0010, BP_A, BP_B, 1'b1, 4'b0010, 1'b1});
    // pointer skip from 2 to 3, wrap to 0, then from 1 back to 3
    vecs.push_back('{1'b0, 4'b1001, SK_A, SK_B, 1'b1, 4'b1000, 1'b1});
    vecs.push_back('{1'b0, 4'b1001, SK_A, SK_B, 1'b1, 4'b0001, 1'b1});
    vecs.push_back('{1'b0, 4'b1001, SK_A, SK_B, 1'b1, 4'b1000, 1'b1});
    vecs.push_back('{1'b0, 4'b0000, 20'd0, 20'd0, 1'b1, 4'b0000, 1'b0});
    // reset mid-stream while holding id 2
    vecs.push_back('{1'b0, 4'b1111, RR_A, 20'd0, 1'b1, 4'b0001, 1'b1});
    vecs.push_back('{1'b0, 4'b1111, RR_A, 20'd0, 1'b1, 4'b0010, 1'b1});
    vecs.push_back('{1'b0, 4'b1111, RR_A, 20'd0, 1'b1, 4'b0100, 1'b1});
    vecs.push_back('{1'b1, 4'b1111, RR_A, 20'd0, 1'b1, 4'b0000, 1'b0});
    vecs.push_back('{1'b0, 4'b1111, RR_A, 20'd0, 1'b1, 4'b0001, 1'b1});
    // valid held without ready, then a stalled request released
    vecs.push_back('{1'b0, 4'b0000, 20'd0, 20'd0, 1'b0, 4'b0000, 1'b1});
    vecs.push_back('{1'b0, 4'b0100, RR_A, 20'd0, 1'b0, 4'b0000, 1'b1});
    vecs.push_back('{1'b0, 4'b0100, RR_A, 20'd0, 1'b1, 4'b0100, 1'b1});

    $display("[TB] directed phase: %0d vectors", vecs.size());
    foreach (vecs[n]) begin
      applyStimulus(vecs[n].rst, vecs[n].req, vecs[n].a, vecs[n].b, vecs[n].rdy, vecs[n].exp_gnt);
      checkOutput(vecs[n].rst, vecs[n].exp_zv);
    end

    $display("[TB] random phase");
    applyStimulus(1'b1, 4'd0, 20'd0, 20'd0, 1'b1, 4'd0);
    checkOutput(1'b1, 1'b0);
    m_ptr = 2'd0; m_zv = 1'b0; pend = 4'd0; ra = '0; rb = '0;
    last_gnt = 4'd0; mon_en = 1'b1;
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) != 0) begin
          pend[i] = 1'b1;
          ra[i*W +: W] = W'($urandom);
          rb[i*W +: W] = W'($urandom);
        end
      end
      rd = ($urandom_range(0, 3) != 0);
      eg = (m_zv && !rd) ? 4'd0 : rr_pick(pend, m_ptr);
      applyStimulus(1'b0, pend, ra, rb, rd, eg);
      if (eg != 4'd0) begin
        for (int i = 0; i < N; i++) if (eg[i]) m_ptr = 2'(i + 1);
        m_zv = 1'b1;
        pend = pend & ~eg;
      end else if (rd) begin
        m_zv = 1'b0;
      end
      checkOutput(1'b0, m_zv);
    end
    mon_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/or_arbiter.md
# or_arbiter

Round-robin arbiter and output stage that shares one WIDTH-bit bitwise-OR datapath among four requesters. Each cycle it selects at most one pending requester and registers that requester's `a | b` result. The result is tagged with the requester index and presented on a valid/ready output port. It sits between the requesting blocks and the downstream consumer of OR results, so multiple producers can use the OR unit without contention.

## Interface

Parameters:
- `WIDTH`, default 5: operand and result width in bits, legal range ≥ 1.
- `NREQ`, default 4: number of requesters. Fixed at 4 for this revision.

Ports:
- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst`  input  1: synchronous, active-high reset.
- `req`  input  NREQ: `req[i]` high means requester i has operands pending.
- `a_in`  input  NREQ*WIDTH: operand A of requester i at bits `[i*WIDTH +: WIDTH]`.
- `b_in`  input  NREQ*WIDTH: operand B of requester i at bits `[i*WIDTH +: WIDTH]`.
- `gnt`  output  NREQ: one-hot or zero, combinational. `gnt[i]` high means requester i is accepted this cycle.
- `z`  output  WIDTH: registered OR result.
- `z_id`  output  2: index of the requester that produced `z`.
- `z_valid`  output  1: `z` and `z_id` are valid.
- `z_ready`  input  1: the consumer accepts `z` this cycle.

## Operation

- **Requester rule:** a requester holds `req[i]` and its operands stable until it sees `gnt[i]`. A transfer occurs on the rising edge when `req[i] && gnt[i]`. The requester may drop `req[i]` or present new operands on the following cycle.
- **Capacity:** the output stage holds one entry. It can accept when `can_accept = !z_valid || z_ready`.
- **Arbitration:**
  - The block keeps a 2-bit priority pointer `ptr`, reset value 0.
  - The search order is `ptr, ptr+1, ptr+2, ptr+3` (mod 4).
  - The first index with `req` high wins.
  - `gnt` is the one-hot encoding of the winner, gated by `can_accept`.
  - `gnt` is all-zero when there are no requests, when `!can_accept`, or while `rst` is high.
- **On a grant to requester i:**
  - `z <= a_i | b_i`
  - `z_id <= i`
  - `z_valid <= 1`
  - `ptr <= (i+1) mod 4`
- **No grant, but `z_valid && z_ready`:** `z_valid <= 0`. `z` and `z_id` hold their last values.
- **No grant, `z_valid && !z_ready`:** all outputs and `ptr` hold.
- **`ptr` update:** `ptr` changes only on a grant.
- **Fairness:** with a continuous `req=4'b1111`, each requester is granted once every 4 cycles. No requester waits more than 3 grants while the output drains.
- **Arithmetic:** bitwise OR per bit, WIDTH in and WIDTH out. No carry and no truncation.

## Timing

- **Reset values (rst high on an edge):**
  - `z_valid=0`, `z=0`, `z_id=0`, `ptr=0`.
  - `gnt=0` combinationally for as long as `rst` is high.
- **Latency:** a grant in cycle N gives `z_valid`, `z` and `z_id` updated in cycle N+1.
- **Throughput:** one result per cycle while `z_ready` is held high.
- **Pass-through under backpressure:** when `z_valid=1` and `z_ready=1`, a grant is allowed in the same cycle. The old result is consumed and the new one loads on the same edge, with no bubble.
- **Stall:** `z_valid=1`, `z_ready=0` gives `gnt=0`. `z` and `z_id` stay stable until the handshake completes (AXI-style stable-while-valid).
- **Simultaneous requests:** resolved only by `ptr`. Request arrival order has no effect.
- **Request withdrawn before grant:** this is illegal. The bench flags `req[i]` falling while `gnt[i]` has not yet been seen.
- **Reset mid-operation:** any pending result is discarded (`z_valid=0` on the next cycle) and `ptr` returns to 0. The first grant after reset goes to the lowest-index active requester.
- **`ptr` wrap-around:** a grant to requester 3 sets `ptr=0`.

## Test plan

- **Reset:** hold `rst=1` for 2 cycles with `req=4'b1111` and `z_ready=1`. Required: `gnt=0` throughout, then `z_valid=0`, `z=0`, `z_id=0`. After release, the first `gnt` is `4'b0001`.
- **Single request:** `req=4'b0001`, `a0=5'b10100`, `b0=5'b00011`, `z_ready=1`. Required: `gnt=4'b0001` in the same cycle. Next cycle `z_valid=1`, `z=5'b10111`, `z_id=0`.
- **Round robin:** `req=4'b1111` held, `z_ready=1`, `a_i=5'b00001<<i`, `b_i=0`. Required:
  - grant sequence 0,1,2,3,0 on consecutive cycles;
  - `z_id` sequence 0,1,2,3,0 one cycle later;
  - `z=1,2,4,8,1`.
- **Backpressure:** with `z_valid=1`, `z_ready=0`, `req=4'b0010`, `a1=5'b11000`, `b1=5'b00001`. Required:
  - `gnt=0` and `z` stable for 3 cycles.
  - Raising `z_ready` gives `gnt=4'b0010` in that cycle.
  - Next cycle `z=5'b11001`, `z_id=1`, `z_valid=1`, with no idle cycle.
- **Pointer skip and wrap:** after a grant to requester 1 (`ptr=2`), apply `req=4'b1001`. Required: grant 3 first, then 0, then `ptr=1`.
- **Reset mid-stream:** `req=4'b1111`, assert `rst` for 1 cycle while `z_valid=1`, `z_id=2`. Required: next cycle `z_valid=0`, `z=0`. The first post-reset grant is requester 0.
